// File: rtl/tau_pkg.sv
// Shared definitions for the streaming tau transpose: mode encodings, bank states
// and MSB-first element slicing.
package tau_pkg;

    localparam logic MODE_TRANSPOSE = 1'b0;
    localparam logic MODE_BYPASS    = 1'b1;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Widest row/element the slicing helper handles.
    localparam int ROW_MAX  = 1024;
    localparam int ELEM_MAX = 64;

    // Element idx of an n-element row of w-bit elements; element 0 sits in the MSBs.
    function automatic logic [ELEM_MAX-1:0] elem(input logic [ROW_MAX-1:0] row,
                                                 input int n, input int w, input int idx);
        logic [ROW_MAX-1:0] sh;
        sh = row >> ((n - 1 - idx) * w);
        return sh[ELEM_MAX-1:0] & ((ELEM_MAX'(1) << w) - ELEM_MAX'(1));
    endfunction

endpackage

// File: rtl/tau_bank.sv
// One N x N matrix bank: row write port plus combinational read of a row (bypass)
// or a column (transpose). Read latency 0; no flow control inside the bank.
module tau_bank
    import tau_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [N*W-1:0] wr_row,
    input  logic          wr_mode,
    input  logic [IW-1:0] rd_idx,
    output logic [N*W-1:0] rd_row,
    output logic          mode
);

    logic [N*W-1:0] rows [N];

    // Mode is captured with the first row so it travels with its matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) rows[r] <= '0;
            mode <= MODE_TRANSPOSE;
        end else if (wr_en) begin
            rows[wr_idx] <= wr_row;
            if (wr_idx == '0) mode <= wr_mode;
        end
    end

    always_comb begin
        rd_row = '0;
        if (mode == MODE_BYPASS) begin
            rd_row = rows[rd_idx];
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (IW'(j) == rd_idx)
                        rd_row[(N-1-i)*W +: W] = W'(elem(ROW_MAX'(rows[i]), N, W, j));
                end
            end
        end
    end

endmodule

// File: rtl/tau_stream.sv
// Streaming N x N transpose/bypass with ping-pong banks, one row per beat.
// First output beat valid the cycle after the Nth input row; no input-to-output comb path.
// in_ready drops only while the write bank is full; outputs hold while out_ready is low.
module tau_stream
    import tau_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_row,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_row,
    output logic           out_last,
    output logic           out_mode
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    bank_state_t    state [2];
    logic           wr_bank;
    logic           rd_bank;
    logic [IW-1:0]  wr_cnt;
    logic [IW-1:0]  rd_cnt;
    logic [1:0]     bank_wr;
    logic [N*W-1:0] bank_rd_row [2];
    logic           bank_mode [2];
    logic           in_fire;
    logic           rd_fire;

    assign in_ready  = (state[wr_bank] != BANK_FULL);
    assign out_valid = (state[rd_bank] == BANK_FULL);
    assign in_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_last  = out_valid && (rd_cnt == LAST);
    assign out_row   = out_valid ? bank_rd_row[rd_bank] : '0;
    assign out_mode  = out_valid && bank_mode[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_wr[b] = in_fire && (wr_bank == 1'(b));

        tau_bank #(.N(N), .W(W)) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bank_wr[b]),
            .wr_idx  (wr_cnt),
            .wr_row  (in_row),
            .wr_mode (in_mode),
            .rd_idx  (rd_cnt),
            .rd_row  (bank_rd_row[b]),
            .mode    (bank_mode[b])
        );
    end

    // A bank is written only when not FULL and read only when FULL, so the two
    // transitions below never target the same bank on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) state[b] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (bank_wr[b])
                    state[b] <= (wr_cnt == LAST) ? BANK_FULL : BANK_FILLING;
                else if (rd_fire && (rd_bank == 1'(b)) && (rd_cnt == LAST))
                    state[b] <= BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_fire) begin
            if (wr_cnt == LAST) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_fire) begin
            if (rd_cnt == LAST) begin
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_cnt <= rd_cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tau_stream.sv
// Bench for tau_stream: directed scenarios on N=4/W=8 plus randomized sweeps on
// N=2/W=16 and N=8/W=8, all scored against queue-based reference models.
module tb_tau_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- directed instance, N=4 W=8 ----------------
    logic        rst_n;
    logic        rst_sw;
    logic        t_in_valid, t_in_ready, t_in_mode;
    logic [31:0] t_in_row;
    logic        t_out_valid, t_out_ready, t_out_last, t_out_mode;
    logic [31:0] t_out_row;

    tau_stream #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (t_in_valid),
        .in_ready  (t_in_ready),
        .in_row    (t_in_row),
        .in_mode   (t_in_mode),
        .out_valid (t_out_valid),
        .out_ready (t_out_ready),
        .out_row   (t_out_row),
        .out_last  (t_out_last),
        .out_mode  (t_out_mode)
    );

    logic [31:0] q_row [$];
    bit          q_last [$];
    bit          q_mode [$];

    always @(negedge clk) begin
        #1;
        if (rst_n && t_out_valid && t_out_ready) begin
            if (q_row.size() == 0) begin
                chk("t_extra_beat", 64'(q_row.size()), 64'(1));
            end else begin
                chk("t_out_row",  64'(t_out_row),  64'(q_row[0]));
                chk("t_out_last", 64'(t_out_last), 64'(q_last[0]));
                chk("t_out_mode", 64'(t_out_mode), 64'(q_mode[0]));
                void'(q_row.pop_front());
                void'(q_last.pop_front());
                void'(q_mode.pop_front());
            end
        end
    end

    task automatic push_mat(input logic [31:0] m [4], input bit md);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r = m[j];
            if (!md)
                for (int i = 0; i < 4; i++) r[31-8*i -: 8] = m[i][31-8*j -: 8];
            q_row.push_back(r);
            q_last.push_back(j == 3);
            q_mode.push_back(md);
        end
    endtask

    task automatic rand_mat(output logic [31:0] m [4]);
        for (int i = 0; i < 4; i++) m[i] = $urandom;
    endtask

    task automatic send_row(input logic [31:0] row, input logic md);
        int budget = 0;
        t_in_valid = 1'b1;
        t_in_row   = row;
        t_in_mode  = md;
        while (!t_in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) chk("t_in_ready_timeout", 64'(t_in_ready), 64'(1));
        @(negedge clk);
        t_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int budget = 0;
        while (q_row.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk(tag, 64'(q_row.size()), 64'(0));
    endtask

    // ---------------- randomized sweep instances ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int NN  = (g == 0) ? 2 : 8;
        localparam int WW  = (g == 0) ? 16 : 8;
        localparam int NNW = NN * WW;
        localparam int NM  = 12;

        logic           iv, ir, im, ov, ordy, ol, om;
        logic [NNW-1:0] irow, orow;
        logic [NNW-1:0] eq_row [$];
        bit             eq_last [$];
        bit             eq_mode [$];
        logic [NNW-1:0] mat [NN];
        int             got = 0;
        bit             done = 1'b0;

        tau_stream #(.N(NN), .W(WW)) u_sw (
            .clk       (clk),
            .rst_n     (rst_sw),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_row    (irow),
            .in_mode   (im),
            .out_valid (ov),
            .out_ready (ordy),
            .out_row   (orow),
            .out_last  (ol),
            .out_mode  (om)
        );

        always @(negedge clk) begin
            ordy = ($urandom_range(3) != 0);
            if (rst_sw && ov && ordy) begin
                if (eq_row.size() == 0) begin
                    chk($sformatf("sw%0d_extra_beat", NN), 64'(eq_row.size()), 64'(1));
                end else begin
                    chk($sformatf("sw%0d_row", NN),  64'(orow), 64'(eq_row[0]));
                    chk($sformatf("sw%0d_last", NN), 64'(ol),   64'(eq_last[0]));
                    chk($sformatf("sw%0d_mode", NN), 64'(om),   64'(eq_mode[0]));
                    void'(eq_row.pop_front());
                    void'(eq_last.pop_front());
                    void'(eq_mode.pop_front());
                end
                got++;
            end
        end

        initial begin
            logic [NNW-1:0] r;
            bit md;
            int budget;
            iv = 1'b0; irow = '0; im = 1'b0;
            wait (rst_sw === 1'b1);
            @(negedge clk);
            for (int m = 0; m < NM; m++) begin
                md = 1'($urandom_range(1));
                for (int i = 0; i < NN; i++) mat[i] = NNW'({$urandom, $urandom});
                for (int j = 0; j < NN; j++) begin
                    r = mat[j];
                    if (!md)
                        for (int i = 0; i < NN; i++) r[(NN-1-i)*WW +: WW] = mat[i][(NN-1-j)*WW +: WW];
                    eq_row.push_back(r);
                    eq_last.push_back(j == NN - 1);
                    eq_mode.push_back(md);
                end
                for (int j = 0; j < NN; j++) begin
                    while ($urandom_range(3) == 0) @(negedge clk);
                    iv = 1'b1; irow = mat[j]; im = md;
                    budget = 0;
                    while (!ir && budget < 500) begin
                        @(negedge clk);
                        budget++;
                    end
                    if (budget >= 500) chk($sformatf("sw%0d_in_timeout", NN), 64'(ir), 64'(1));
                    @(negedge clk);
                    iv = 1'b0;
                end
            end
            budget = 0;
            while (eq_row.size() != 0 && budget < 2000) begin
                @(negedge clk);
                budget++;
            end
            repeat (4) @(negedge clk);
            chk($sformatf("sw%0d_drain", NN), 64'(eq_row.size()), 64'(0));
            chk($sformatf("sw%0d_beats", NN), 64'(got), 64'(NM * NN));
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] c [4];
        logic [31:0] m3 [3][4];
        logic [31:0] tmp [4];
        bit          md3 [3];
        int          budget;

        a = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        rst_n = 1'b0; rst_sw = 1'b0;
        t_in_valid = 1'b0; t_in_row = '0; t_in_mode = 1'b0; t_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(t_in_ready),  64'(1));
        chk("rst_out_valid", 64'(t_out_valid), 64'(0));
        chk("rst_out_row",   64'(t_out_row),   64'(0));
        chk("rst_out_last",  64'(t_out_last),  64'(0));
        chk("rst_out_mode",  64'(t_out_mode),  64'(0));
        rst_n = 1'b1; rst_sw = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  64'(t_in_ready),  64'(1));
        chk("rel_out_valid", 64'(t_out_valid), 64'(0));

        // Basic transpose with known answers
        t_out_ready = 1'b1;
        q_row  = '{32'h0105090D, 32'h02060A0E, 32'h03070B0F, 32'h04080C10};
        q_last = '{0, 0, 0, 1};
        q_mode = '{0, 0, 0, 0};
        for (int r = 0; r < 4; r++) begin
            if (r == 3) chk("t1_valid_early", 64'(t_out_valid), 64'(0));
            send_row(a[r], 1'b0);
        end
        chk("t1_latency", 64'(t_out_valid), 64'(1));
        wait_drain("t1_drain");

        // Bypass
        push_mat(a, 1'b1);
        for (int r = 0; r < 4; r++) send_row(a[r], 1'b1);
        wait_drain("t2_drain");

        // Back-to-back, modes 0,1,0
        md3 = '{0, 1, 0};
        for (int m = 0; m < 3; m++) begin
            rand_mat(tmp);
            m3[m] = tmp;
            push_mat(tmp, md3[m]);
        end
        fork
            begin
                for (int m = 0; m < 3; m++)
                    for (int r = 0; r < 4; r++) begin
                        chk("t3_in_ready", 64'(t_in_ready), 64'(1));
                        send_row(m3[m][r], md3[m]);
                    end
            end
            begin
                int bw = 0;
                while (!t_out_valid && bw < 50) begin
                    @(negedge clk);
                    bw++;
                end
                for (int k = 0; k < 12; k++) begin
                    chk("t3_out_valid_cont", 64'(t_out_valid), 64'(1));
                    @(negedge clk);
                end
            end
        join
        wait_drain("t3_drain");

        // Backpressure: two matrices fill both banks
        t_out_ready = 1'b0;
        rand_mat(b);
        rand_mat(c);
        push_mat(a, 1'b0);
        push_mat(b, 1'b0);
        for (int r = 0; r < 4; r++) send_row(a[r], 1'b0);
        for (int r = 0; r < 4; r++) send_row(b[r], 1'b0);
        chk("t4_in_ready_full", 64'(t_in_ready), 64'(0));
        chk("t4_hold_row", 64'(t_out_row), 64'h0105090D);
        t_in_valid = 1'b1; t_in_row = c[0]; t_in_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_in_ready", 64'(t_in_ready), 64'(0));
            chk("t4_stall_row", 64'(t_out_row), 64'h0105090D);
            chk("t4_stall_last", 64'(t_out_last), 64'(0));
        end
        t_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_in_ready_beat3", 64'(t_in_ready), 64'(0));
        @(negedge clk);
        chk("t4_in_ready_beat4", 64'(t_in_ready), 64'(1));
        @(negedge clk);
        t_in_valid = 1'b0;
        wait_drain("t4_drain");

        // Reset with one full matrix pending and two rows of the next
        t_out_ready = 1'b0;
        for (int r = 1; r < 4; r++) send_row(c[r], 1'b0);
        send_row(b[0], 1'b0);
        send_row(b[1], 1'b0);
        chk("t5_pending", 64'(t_out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 64'(t_out_valid), 64'(0));
        chk("t5_rst_in_ready",  64'(t_in_ready),  64'(1));
        chk("t5_rst_out_row",   64'(t_out_row),   64'(0));
        chk("t5_rst_out_mode",  64'(t_out_mode),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rel_out_valid", 64'(t_out_valid), 64'(0));
        t_out_ready = 1'b1;
        rand_mat(tmp);
        push_mat(tmp, 1'b0);
        for (int r = 0; r < 4; r++) send_row(tmp[r], 1'b0);
        wait_drain("t5_drain");
        repeat (6) @(negedge clk);
        chk("t5_no_stale", 64'(t_out_valid), 64'(0));

        budget = 0;
        while (!(g_sw[0].done && g_sw[1].done) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        chk("sweep_done", 64'(g_sw[0].done && g_sw[1].done), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tau_stream.md
Name: tau_stream

Overview:
- Streaming, parametrised successor to the fixed 4x4 byte transpose (tau), for datapaths that deliver a state matrix one row per beat instead of as a flat vector.
- Accepts an N x N matrix of W-bit elements row by row and emits it column by column, i.e. b(i,j)=a(j,i).
- Ping-pong storage of two matrix banks: one matrix fills while the previous one drains, so sustained throughput is one row per cycle.
- Per-matrix bypass mode emits rows unchanged, so one instance serves both the tau and identity steps of a round pipeline.

Parameters:
N, 4, matrix dimension (rows = columns = beats per matrix), N >= 2
W, 8, element width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input row valid
in_ready  output  1  block can accept an input row
in_row  input  N*W  input row; element 0 in MSBs [N*W-1 -: W], element N-1 in LSBs
in_mode  input  1  0 = transpose, 1 = bypass; sampled only on the first row of a matrix
out_valid  output  1  output row valid
out_ready  input  1  downstream accepts output row
out_row  output  N*W  output row, same element ordering as in_row
out_last  output  1  high with the final beat (beat N-1) of a matrix
out_mode  output  1  mode of the matrix currently being drained

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready. in_row, in_mode and out_ready may change only outside transfers. in_ready and out_valid are registered state and never depend combinationally on in_valid or out_ready.
- Storage: two banks (0/1), each holding N rows plus a mode bit and a state: EMPTY -> FILLING -> FULL -> EMPTY.
  - EMPTY -> FILLING on the first row written.
  - FILLING -> FULL on the Nth row written.
  - FULL -> EMPTY on the Nth row read.
- Write side: wr_bank pointer and wr_cnt (0..N-1).
  - in_ready = state[wr_bank] != FULL.
  - Each input transfer stores in_row at row wr_cnt of wr_bank and increments wr_cnt.
  - When wr_cnt = 0, in_mode is also latched into the bank.
  - When wr_cnt = N-1, wr_cnt wraps to 0 and wr_bank toggles.
- Read side: rd_bank pointer and rd_cnt (0..N-1).
  - out_valid = state[rd_bank] == FULL.
  - Transpose mode: out_row element i = bank[rd_bank] row i, element rd_cnt.
  - Bypass mode: out_row = bank[rd_bank] row rd_cnt.
  - out_last = out_valid && rd_cnt == N-1.
  - On each output transfer rd_cnt increments. On the last beat rd_cnt wraps to 0, the bank goes EMPTY and rd_bank toggles.
- Latency: the first output beat is valid the cycle after the Nth input row is accepted. There is no combinational path from input to output.
- Throughput: with out_ready held high, the input never stalls. Continuous matrices flow at 1 row/cycle; out_valid stays high continuously once the pipeline is primed.
- Simultaneous events:
  - Writing one bank while reading the other is always legal.
  - A bank freed by the last read on edge k shows in_ready=1 from cycle k+1. This is registered; there is no same-cycle reuse.
- Both banks FULL: in_ready=0 until the draining bank empties.
- Backpressure: while out_valid && !out_ready, out_row, out_last and out_mode stay stable.
- Reset (any time, including mid-matrix): asynchronously clears all bank states to EMPTY, all pointers/counters to 0, stored rows and mode bits to 0.
  - Partial or pending matrices are discarded.
  - Outputs while reset is asserted and after release: in_ready=1, out_valid=0, out_row=0, out_last=0, out_mode=0.

Decomposition:
- Shared package tau_pkg: MODE_TRANSPOSE=1'b0, MODE_BYPASS=1'b1; bank state enum (BANK_EMPTY, BANK_FILLING, BANK_FULL, 2 bits); function for element slicing elem(row,idx) with MSB-first ordering.
- One sub-module, tau_bank: storage for a single N x N matrix plus mode, write-row port and combinational column/row read port selected by mode and index. tau_stream instantiates two tau_bank and holds the pointers, counters and state machines.

Test Plan:
- Basic transpose (N=4, W=8), out_ready=1.
  - Stimulus: rows 01020304, 05060708, 090A0B0C, 0D0E0F10, mode 0.
  - Required response: outputs 01050 90D, 02060A0E, 03070B0F, 04080C10, written as 0105090D, 02060A0E, 03070B0F, 04080C10; out_last on the 4th beat; first out_valid exactly 1 cycle after the 4th input transfer.
- Bypass: same rows with mode 1 -> outputs identical to inputs in order; out_mode=1 on all four beats.
- Back-to-back with mixed modes.
  - Stimulus: 3 consecutive matrices, modes 0,1,0, in_valid and out_ready always 1.
  - Required response: in_ready never drops; 12 output beats in order with correct per-matrix mode.
- Backpressure.
  - Stimulus: out_ready=0 while sending 2 full matrices, then a 9th row offered.
  - Required response: in_ready=0 after the 8th row; out_row held at 0105090D; after out_ready=1, in_ready returns to 1 the cycle after the 4th output beat.
- Reset mid-operation.
  - Stimulus: assert rst_n=0 after 2 rows of a matrix and with 1 full matrix pending.
  - Required response: immediately out_valid=0, in_ready=1, out_row=0; after release, a fresh matrix transposes correctly with no stale beats.
- Parameter sweep: N=2, W=16 and N=8, W=8 with random data and random valid/ready -> scoreboard b(i,j)=a(j,i), no lost or duplicated beats.
